// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port mem_controller between the CPU data
// port and the camera frame-writer. The CPU has fixed priority. A starvation
// counter forces a camera grant after MAX_WAIT consecutive denied cycles. The
// winner is registered onto the memory bus. A {valid, owner} tag pipeline sends
// returned read data back to the requester that issued the read.
// Optional: define MEM_ARB_STATS_EN to add the grant counters and the
// cam_starved flag.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              cam_req,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_gnt,
  output logic [DATA_W-1:0] cam_rdata,
  output logic              cam_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_grant_cnt,
  output logic [15:0]       cam_grant_cnt,
  output logic              cam_starved
`endif
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              force_cam;
  logic [READ_LAT:0] tag_vld;
  logic [READ_LAT:0] tag_cam;
  logic              ret_vld;
  logic              ret_cam;

  // Grant decode: CPU wins unless the camera has waited MAX_WAIT cycles.
  // No grants while reset is held.
  always_comb begin
    force_cam = cam_req && (wait_cnt == MAX_WAIT_C);
    cpu_gnt   = !reset && cpu_req && !force_cam;
    cam_gnt   = !reset && cam_req && (force_cam || !cpu_req);
  end

  // Starvation counter: count denied camera cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (cam_gnt) begin
      wait_cnt <= '0;
    end else if (cam_req && (wait_cnt < MAX_WAIT_C)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Register the accepted request onto the memory bus.
  // Address and data hold their values when the bus is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
    end else if (cpu_gnt) begin
      mem_address <= cpu_addr;
      mem_data_in <= cpu_wdata;
      mem_we      <= cpu_we;
    end else if (cam_gnt) begin
      mem_address <= cam_addr;
      mem_data_in <= cam_wdata;
      mem_we      <= cam_we;
    end else begin
      mem_we      <= 1'b0;
    end
  end

  // Read tag pipeline. Stage k is valid in the (k+1)th cycle after the grant,
  // so the last stage lines up with valid mem_data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_cam <= '0;
    end else begin
      tag_vld[0] <= (cpu_gnt && !cpu_we) || (cam_gnt && !cam_we);
      tag_cam[0] <= cam_gnt;
      for (int i = 1; i <= READ_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_cam[i] <= tag_cam[i-1];
      end
    end
  end

  assign ret_vld = tag_vld[READ_LAT];
  assign ret_cam = tag_cam[READ_LAT];

  // Capture returning read data for its owner.
  // The other requester keeps its last data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata  <= '0;
      cam_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      cam_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= ret_vld && !ret_cam;
      cam_rvalid <= ret_vld && ret_cam;
      if (ret_vld && !ret_cam) cpu_rdata <= mem_data_out;
      if (ret_vld && ret_cam)  cam_rdata <= mem_data_out;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating grant counters.
  // cam_starved flags the cycle after a forced camera grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_grant_cnt <= '0;
      cam_grant_cnt <= '0;
      cam_starved   <= 1'b0;
    end else begin
      if (cpu_gnt && (cpu_grant_cnt != 16'hFFFF)) cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (cam_gnt && (cam_grant_cnt != 16'hFFFF)) cam_grant_cnt <= cam_grant_cnt + 16'd1;
      cam_starved <= cam_gnt && force_cam;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It runs two instances on shared stimulus:
// dut0 with READ_LAT=0 and dut2 with READ_LAT=2. Each instance has its own
// behavioural memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cam_req, cam_we;
  logic [31:0] cpu_addr, cpu_wdata, cam_addr, cam_wdata;

  logic        d0_cpu_gnt, d0_cpu_rvalid, d0_cam_gnt, d0_cam_rvalid, d0_mem_we;
  logic [31:0] d0_cpu_rdata, d0_cam_rdata, d0_mem_address, d0_mem_data_in, d0_mem_data_out;
  logic        d2_cpu_gnt, d2_cpu_rvalid, d2_cam_gnt, d2_cam_rvalid, d2_mem_we;
  logic [31:0] d2_cpu_rdata, d2_cam_rdata, d2_mem_address, d2_mem_data_in, d2_mem_data_out;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] d0_cpu_cnt, d0_cam_cnt, d2_cpu_cnt, d2_cam_cnt;
  logic        d0_starved, d2_starved;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(0), .MAX_WAIT(4)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d0_cpu_gnt), .cpu_rdata(d0_cpu_rdata), .cpu_rvalid(d0_cpu_rvalid),
    .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
    .cam_gnt(d0_cam_gnt), .cam_rdata(d0_cam_rdata), .cam_rvalid(d0_cam_rvalid),
    .mem_address(d0_mem_address), .mem_data_in(d0_mem_data_in), .mem_we(d0_mem_we),
    .mem_data_out(d0_mem_data_out)
`ifdef MEM_ARB_STATS_EN
    , .cpu_grant_cnt(d0_cpu_cnt), .cam_grant_cnt(d0_cam_cnt), .cam_starved(d0_starved)
`endif
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2), .MAX_WAIT(4)) dut2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(d2_cpu_gnt), .cpu_rdata(d2_cpu_rdata), .cpu_rvalid(d2_cpu_rvalid),
    .cam_req(cam_req), .cam_we(cam_we), .cam_addr(cam_addr), .cam_wdata(cam_wdata),
    .cam_gnt(d2_cam_gnt), .cam_rdata(d2_cam_rdata), .cam_rvalid(d2_cam_rvalid),
    .mem_address(d2_mem_address), .mem_data_in(d2_mem_data_in), .mem_we(d2_mem_we),
    .mem_data_out(d2_mem_data_out)
`ifdef MEM_ARB_STATS_EN
    , .cpu_grant_cnt(d2_cpu_cnt), .cam_grant_cnt(d2_cam_cnt), .cam_starved(d2_starved)
`endif
  );

  // Memory models, indexed by address bits [19:16]. The 0-latency model reads
  // combinationally. The 2-latency model delays read data by two registers.
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] rd_b1, rd_b2;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rd_b1 = '0;
    rd_b2 = '0;
  end

  always @(posedge clk) begin
    if (d0_mem_we) mem_a[d0_mem_address[19:16]] <= d0_mem_data_in;
    if (d2_mem_we) mem_b[d2_mem_address[19:16]] <= d2_mem_data_in;
    rd_b1 <= mem_b[d2_mem_address[19:16]];
    rd_b2 <= rd_b1;
  end

  assign d0_mem_data_out = mem_a[d0_mem_address[19:16]];
  assign d2_mem_data_out = rd_b2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Inputs are driven at posedge+1 and checks follow at
  // posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cam_req = 0; cam_we = 0; cam_addr = 0; cam_wdata = 0;
    tick(); tick(); tick();

    // Reset state: no grants while in reset even with requests pending.
    cpu_req = 1; cam_req = 1;
    #1;
    chk("rst_cpu_gnt", 32'(d0_cpu_gnt), 0);
    chk("rst_cam_gnt", 32'(d0_cam_gnt), 0);
    chk("rst_mem_we", 32'(d0_mem_we), 0);
    chk("rst_mem_addr", d0_mem_address, 0);
    chk("rst_mem_din", d0_mem_data_in, 0);
    chk("rst_cpu_rdata", d0_cpu_rdata, 0);
    chk("rst_cam_rdata", d0_cam_rdata, 0);
    chk("rst_cpu_rvalid", 32'(d0_cpu_rvalid), 0);
    chk("rst_cam_rvalid", 32'(d0_cam_rvalid), 0);
    tick();
    reset = 0; cpu_req = 0; cam_req = 0;
    tick();

    // CPU write 16 to 'h50000, then read it back.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50000; cpu_wdata = 32'd16;
    #1;
    chk("t1_wr_cpu_gnt", 32'(d0_cpu_gnt), 1);
    chk("t1_wr_cam_gnt", 32'(d0_cam_gnt), 0);
    tick();
    cpu_we = 0;
    #1;
    chk("t1_rd_cpu_gnt", 32'(d0_cpu_gnt), 1);
    chk("t1_issue_we", 32'(d0_mem_we), 1);
    chk("t1_issue_addr", d0_mem_address, 32'h50000);
    chk("t1_issue_din", d0_mem_data_in, 32'd16);
    tick();
    cpu_req = 0;
    #1;
    chk("t1_rd_issue_we", 32'(d0_mem_we), 0);
    chk("t1_rd_issue_addr", d0_mem_address, 32'h50000);
    chk("t1_hold_din", d0_mem_data_in, 32'd16);
    chk("t1_rvalid_early", 32'(d0_cpu_rvalid), 0);
    tick();
    chk("t1_cpu_rvalid", 32'(d0_cpu_rvalid), 1);
    chk("t1_cpu_rdata", d0_cpu_rdata, 32'd16);
    chk("t1_cam_rvalid", 32'(d0_cam_rvalid), 0);
    chk("t1_idle_we", 32'(d0_mem_we), 0);
    tick();
    chk("t1_rvalid_pulse", 32'(d0_cpu_rvalid), 0);
    chk("t1_lat2_not_yet", 32'(d2_cpu_rvalid), 0);
    tick();

    // Camera alone: write 20 to 'h80000, then read it back.
    // The READ_LAT=2 instance returns the earlier CPU read in this cycle.
    chk("t1_lat2_cpu_rvalid", 32'(d2_cpu_rvalid), 1);
    chk("t1_lat2_cpu_rdata", d2_cpu_rdata, 32'd16);
    cam_req = 1; cam_we = 1; cam_addr = 32'h80000; cam_wdata = 32'd20;
    #1;
    chk("t2_wr_cam_gnt", 32'(d0_cam_gnt), 1);
    chk("t2_wr_cpu_gnt", 32'(d0_cpu_gnt), 0);
    tick();
    cam_we = 0;
    #1;
    chk("t2_rd_cam_gnt", 32'(d0_cam_gnt), 1);
    chk("t2_issue_we", 32'(d0_mem_we), 1);
    chk("t2_issue_addr", d0_mem_address, 32'h80000);
    chk("t2_issue_din", d0_mem_data_in, 32'd20);
    tick();
    cam_req = 0;
    tick();
    chk("t2_cam_rvalid", 32'(d0_cam_rvalid), 1);
    chk("t2_cam_rdata", d0_cam_rdata, 32'd20);
    chk("t2_cpu_rvalid", 32'(d0_cpu_rvalid), 0);
    chk("t2_cpu_rdata_hold", d0_cpu_rdata, 32'd16);
    tick();
    chk("t2_cam_rvalid_pulse", 32'(d0_cam_rvalid), 0);
    tick();
    chk("t2_lat2_cam_rvalid", 32'(d2_cam_rvalid), 1);
    chk("t2_lat2_cam_rdata", d2_cam_rdata, 32'd20);
    chk("t2_lat2_cpu_rvalid", 32'(d2_cpu_rvalid), 0);

    // Contention: both write continuously. The camera wins every 5th cycle.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h50000; cpu_wdata = 32'd16;
    cam_req = 1; cam_we = 1; cam_addr = 32'h80000; cam_wdata = 32'd20;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_cpu_gnt_%0d", i), 32'(d0_cpu_gnt), (i % 5 == 4) ? 0 : 1);
      chk($sformatf("t3_cam_gnt_%0d", i), 32'(d0_cam_gnt), (i % 5 == 4) ? 1 : 0);
      if (i > 0)
        chk($sformatf("t3_addr_%0d", i), d0_mem_address,
            ((i - 1) % 5 == 4) ? 32'h80000 : 32'h50000);
      tick();
    end
    cpu_req = 0; cam_req = 0; cpu_we = 0; cam_we = 0;
    tick(); tick();

    // Back-to-back interleaved reads: CPU, camera, CPU, camera.
    for (int c = 0; c < 9; c++) begin
      cpu_req = (c == 0 || c == 2);
      cam_req = (c == 1 || c == 3);
      cpu_addr = 32'h50000;
      cam_addr = 32'h80000;
      #1;
      chk($sformatf("t4_l0_cpu_rv_%0d", c), 32'(d0_cpu_rvalid), (c == 2 || c == 4) ? 1 : 0);
      chk($sformatf("t4_l0_cam_rv_%0d", c), 32'(d0_cam_rvalid), (c == 3 || c == 5) ? 1 : 0);
      chk($sformatf("t4_l2_cpu_rv_%0d", c), 32'(d2_cpu_rvalid), (c == 4 || c == 6) ? 1 : 0);
      chk($sformatf("t4_l2_cam_rv_%0d", c), 32'(d2_cam_rvalid), (c == 5 || c == 7) ? 1 : 0);
      chk($sformatf("t4_l2_cpu_rd_%0d", c), d2_cpu_rdata, 32'd16);
      chk($sformatf("t4_l2_cam_rd_%0d", c), d2_cam_rdata, 32'd20);
      tick();
    end
    cpu_req = 0; cam_req = 0;

    // Reset one cycle after a CPU read grant: that read never returns.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50000;
    #1;
    chk("t5_cpu_gnt", 32'(d0_cpu_gnt), 1);
    tick();
    cpu_req = 0; reset = 1;
    tick();
    reset = 0;
    #1;
    chk("t5_mem_addr", d0_mem_address, 0);
    chk("t5_mem_din", d0_mem_data_in, 0);
    chk("t5_mem_we", 32'(d0_mem_we), 0);
    chk("t5_cpu_rdata", d0_cpu_rdata, 0);
    chk("t5_cam_rdata", d0_cam_rdata, 0);
    chk("t5_l2_cpu_rdata", d2_cpu_rdata, 0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t5_l0_cpu_rv_%0d", k), 32'(d0_cpu_rvalid), 0);
      chk($sformatf("t5_l2_cpu_rv_%0d", k), 32'(d2_cpu_rvalid), 0);
      tick();
    end

`ifdef MEM_ARB_STATS_EN
    // Grant counters and the forced-grant flag.
    cpu_req = 1; cpu_we = 1;
    tick(); tick(); tick();
    cpu_req = 0; cam_req = 1; cam_we = 1;
    tick(); tick();
    cam_req = 0;
    #1;
    chk("t6_cpu_cnt", 32'(d0_cpu_cnt), 3);
    chk("t6_cam_cnt", 32'(d0_cam_cnt), 2);
    chk("t6_starved_idle", 32'(d0_starved), 0);
    cpu_req = 1; cam_req = 1;
    tick(); tick(); tick(); tick();
    #1;
    chk("t6_forced_gnt", 32'(d0_cam_gnt), 1);
    tick();
    cpu_req = 0; cam_req = 0;
    #1;
    chk("t6_starved_pulse", 32'(d0_starved), 1);
    tick();
    chk("t6_starved_clear", 32'(d0_starved), 0);
    chk("t6_cpu_cnt2", 32'(d0_cpu_cnt), 7);
    chk("t6_cam_cnt2", 32'(d0_cam_cnt), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
